recv_packet_ddr: RTL

Receive-side counterpart of the DDR packet transmitter. Takes frames from the TSE Avalon-ST receive FIFO interface (ff_rx_*) and packs them into 256-bit words. It writes them to DDR through the team's simple RAM write-request port, in the packet-buffer format the transmit path consumes:
- word at start address: bits[10:0] = byte length, all other bits 0;
- data words at start+1 onward, 32 bytes per word.
The length word is written last, so a reader never sees a length before the data is present.

---
 rtl/pkt_ddr_pkg.sv | 26 ++
 rtl/rx_word_packer.sv | 44 ++++
 rtl/recv_packet_ddr.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pkt_ddr_pkg.sv
// Shared constants, FSM state encoding and byte-lane mapping for the DDR packet-buffer
// transmit and receive paths.
package pkt_ddr_pkg;

  localparam int unsigned LEN_W          = 11;
  localparam int unsigned RAM_ADDR_W     = 25;
  localparam int unsigned WORD_W         = 256;
  localparam int unsigned BYTES_PER_WORD = 32;
  localparam int unsigned IDX_W          = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    WR_DATA = 3'd2,
    WR_LEN  = 3'd3,
    SKIP    = 3'd4
  } state_t;

  // MSB of packet byte j inside a 256-bit word: 32-bit lanes, first byte of a lane on top.
  function automatic int unsigned byte_msb(input int unsigned j);
    int unsigned k;
    k = j % BYTES_PER_WORD;
    return (k / 4) * 32 + 31 - 8 * (k % 4);
  endfunction

endpackage

// File: rtl/rx_word_packer.sv
// Byte-in / 256-bit-out word assembler. A clear together with a store makes the
// stored byte the first byte of a fresh word.
module rx_word_packer
  import pkt_ddr_pkg::*;
(
  input  logic              clk_original,
  input  logic              rst,
  input  logic              clear,
  input  logic              store,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word_nxt_c,
  output logic              full_c
);

  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [WORD_W-1:0] base_word;
  logic [IDX_W-1:0]  base_idx;

  always_comb begin
    base_word  = clear ? '0 : word;
    base_idx   = clear ? '0 : idx;
    word_nxt_c = base_word;
    idx_nxt    = base_idx;
    full_c     = 1'b0;
    if (store) begin
      word_nxt_c[8'(byte_msb(32'(base_idx))) -: 8] = data;
      idx_nxt = base_idx + IDX_W'(1);
      full_c  = (base_idx == IDX_W'(BYTES_PER_WORD - 1));
    end
  end

  always_ff @(posedge clk_original or posedge rst) begin
    if (rst) begin
      word <= '0;
      idx  <= '0;
    end else begin
      word <= word_nxt_c;
      idx  <= idx_nxt;
    end
  end

endmodule

// File: rtl/recv_packet_ddr.sv
// Receives TSE ff_rx frames and stores them in DDR as a packet buffer: data words at
// base+1 onward, then the length word at base once all data is written.
module recv_packet_ddr
  import pkt_ddr_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 256
) (
  input  logic                  clk_original,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [RAM_ADDR_W-1:0] start_ram_addr,
  input  logic [7:0]            ff_rx_data,
  input  logic                  ff_rx_sop,
  input  logic                  ff_rx_eop,
  input  logic                  ff_rx_err,
  input  logic                  ff_rx_dval,
  output logic                  ff_rx_rdy,
  output logic [RAM_ADDR_W-1:0] ram_wr_addr,
  output logic [WORD_W-1:0]     ram_wr_data,
  output logic                  ram_wr_req,
  input  logic                  ram_wr_ack,
  output logic                  pkt_done,
  output logic                  pkt_drop,
  output logic [LEN_W-1:0]      pkt_len,
  output logic                  busy
);

  localparam int unsigned CNT_W = LEN_W + 1;

  state_t                state, state_nxt;
  logic [RAM_ADDR_W-1:0] base_addr, base_nxt;
  logic [RAM_ADDR_W-1:0] word_idx, word_idx_nxt;
  logic [RAM_ADDR_W-1:0] addr_nxt;
  logic [LEN_W-1:0]      byte_cnt, byte_cnt_nxt;
  logic [LEN_W-1:0]      len, len_nxt;
  logic [LEN_W-1:0]      pkt_len_nxt;
  logic                  eop_seen, eop_seen_nxt;
  logic                  wr_zero, wr_zero_nxt;
  logic                  req_nxt, done_nxt, drop_nxt;
  logic [WORD_W-1:0]     data_nxt;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  beat, xfer, start, over;
  logic                  pk_clear, pk_store, pk_full;
  logic [WORD_W-1:0]     pk_word_nxt;

  assign ff_rx_rdy = ~rst & ((state == IDLE) | (state == RECV) | (state == SKIP));
  assign busy      = (state != IDLE);
  assign beat      = ff_rx_dval & ff_rx_rdy;
  assign xfer      = ram_wr_req & ram_wr_ack;
  assign cnt_inc   = {1'b0, byte_cnt} + CNT_W'(1);

  // Packer control depends only on state and inputs, keeping it out of the FSM loop.
  always_comb begin
    start    = beat & ff_rx_sop & (((state == IDLE) & enable) | (state == RECV));
    over     = beat & ~ff_rx_sop & (state == RECV) & (cnt_inc > CNT_W'(MAX_BYTES));
    pk_store = start | (beat & ~ff_rx_sop & (state == RECV) & ~over);
    pk_clear = start | ((state == WR_DATA) & xfer);
  end

  rx_word_packer u_packer (
    .clk_original (clk_original),
    .rst          (rst),
    .clear        (pk_clear),
    .store        (pk_store),
    .data         (ff_rx_data),
    .word_nxt_c   (pk_word_nxt),
    .full_c       (pk_full)
  );

  always_comb begin
    state_nxt    = state;
    base_nxt     = base_addr;
    word_idx_nxt = word_idx;
    byte_cnt_nxt = byte_cnt;
    len_nxt      = len;
    eop_seen_nxt = eop_seen;
    wr_zero_nxt  = wr_zero;
    req_nxt      = ram_wr_req;
    addr_nxt     = ram_wr_addr;
    data_nxt     = ram_wr_data;
    done_nxt     = 1'b0;
    drop_nxt     = 1'b0;
    pkt_len_nxt  = pkt_len;

    case (state)
      IDLE: begin
        if (beat & ff_rx_sop & ~enable & ~ff_rx_eop) begin
          state_nxt   = SKIP;
          wr_zero_nxt = 1'b0;
        end
      end
      RECV: begin
        if (over) begin
          if (ff_rx_eop) begin
            state_nxt = WR_LEN;
            len_nxt   = '0;
            req_nxt   = 1'b1;
            addr_nxt  = base_addr;
            data_nxt  = '0;
          end else begin
            state_nxt   = SKIP;
            wr_zero_nxt = 1'b1;
          end
        end
      end
      WR_DATA: begin
        if (xfer) begin
          word_idx_nxt = word_idx + RAM_ADDR_W'(1);
          if (eop_seen) begin
            state_nxt = WR_LEN;
            len_nxt   = byte_cnt;
            addr_nxt  = base_addr;
            data_nxt  = WORD_W'(byte_cnt);
          end else begin
            state_nxt = RECV;
            req_nxt   = 1'b0;
          end
        end
      end
      WR_LEN: begin
        if (xfer) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
          if (len != '0) begin
            done_nxt    = 1'b1;
            pkt_len_nxt = len;
          end else begin
            drop_nxt = 1'b1;
          end
        end
      end
      SKIP: begin
        if (beat & ff_rx_eop) begin
          if (wr_zero) begin
            state_nxt = WR_LEN;
            len_nxt   = '0;
            req_nxt   = 1'b1;
            addr_nxt  = base_addr;
            data_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (start) begin
      if (state == IDLE) base_nxt = start_ram_addr;
      word_idx_nxt = '0;
      byte_cnt_nxt = LEN_W'(1);
    end else if (pk_store) begin
      byte_cnt_nxt = cnt_inc[LEN_W-1:0];
    end

    // Any stored byte decides between errored drop, word write, or collecting more.
    if (pk_store) begin
      if (ff_rx_eop & ff_rx_err) begin
        state_nxt = WR_LEN;
        len_nxt   = '0;
        req_nxt   = 1'b1;
        addr_nxt  = base_nxt;
        data_nxt  = '0;
      end else if (pk_full | ff_rx_eop) begin
        state_nxt    = WR_DATA;
        eop_seen_nxt = ff_rx_eop;
        req_nxt      = 1'b1;
        addr_nxt     = base_nxt + RAM_ADDR_W'(1) + word_idx_nxt;
        data_nxt     = pk_word_nxt;
      end else begin
        state_nxt = RECV;
      end
    end
  end

  always_ff @(posedge clk_original or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      base_addr   <= '0;
      word_idx    <= '0;
      byte_cnt    <= '0;
      len         <= '0;
      eop_seen    <= 1'b0;
      wr_zero     <= 1'b0;
      ram_wr_req  <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      pkt_done    <= 1'b0;
      pkt_drop    <= 1'b0;
      pkt_len     <= '0;
    end else begin
      state       <= state_nxt;
      base_addr   <= base_nxt;
      word_idx    <= word_idx_nxt;
      byte_cnt    <= byte_cnt_nxt;
      len         <= len_nxt;
      eop_seen    <= eop_seen_nxt;
      wr_zero     <= wr_zero_nxt;
      ram_wr_req  <= req_nxt;
      ram_wr_addr <= addr_nxt;
      ram_wr_data <= data_nxt;
      pkt_done    <= done_nxt;
      pkt_drop    <= drop_nxt;
      pkt_len     <= pkt_len_nxt;
    end
  end

endmodule
